// File: rtl/uart_wb_bridge.sv
// Serial debug command responder: decodes WRITE/READ/PING frames from the UART
// receive path, runs single-word Wishbone cycles and returns the result bytes.
module uart_wb_bridge #(
  parameter int unsigned RX_TIMEOUT  = 1000000,
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_re,
  input  logic        tx_empty,
  output logic        tx_we,
  output logic [7:0]  tx_data,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS, SEND, SEND_WAIT
  } state_t;

  localparam logic [31:0] RX_LIM  = 32'(RX_TIMEOUT - 1);
  localparam logic [31:0] BUS_LIM = 32'(BUS_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rsp_q, rsp_d;
  logic [2:0]  rsp_left_q, rsp_left_d;
  logic        rx_re_q, rx_re_d;
  logic        rx_hold_q;
  logic [31:0] rx_tmo_q, rx_tmo_d;
  logic [31:0] bus_tmo_q, bus_tmo_d;
  logic        tx_we_q, tx_we_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  err_q, err_d;
  logic        busy_q;
  logic        rx_take;
  logic        err_inc;

  // The UART valid flag lags the read strobe, so skip the strobe cycle and the one after.
  assign rx_take = rx_valid & ~rx_re_q & ~rx_hold_q;

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    rsp_d      = rsp_q;
    rsp_left_d = rsp_left_q;
    rx_re_d    = 1'b0;
    rx_tmo_d   = rx_tmo_q;
    bus_tmo_d  = bus_tmo_q;
    tx_we_d    = 1'b0;
    tx_data_d  = tx_data_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    err_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        rx_tmo_d = '0;
        if (rx_take) begin
          rx_re_d = 1'b1;
          cnt_d   = 2'd0;
          case (rx_data)
            8'h01: begin is_write_d = 1'b1; state_d = GET_ADDR; end
            8'h02: begin is_write_d = 1'b0; state_d = GET_ADDR; end
            8'h03: begin rsp_d = 32'h5A; rsp_left_d = 3'd1; state_d = SEND; end
            default: begin
              rsp_d      = 32'hEE;
              rsp_left_d = 3'd1;
              err_inc    = 1'b1;
              state_d    = SEND;
            end
          endcase
        end
      end
      GET_ADDR, GET_DATA: begin
        if (rx_take) begin
          rx_re_d  = 1'b1;
          rx_tmo_d = '0;
          cnt_d    = cnt_q + 2'd1;
          if (state_q == GET_ADDR) addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
          else                     wdat_d[{cnt_q, 3'b000} +: 8] = rx_data;
          if (cnt_q == 2'd3) begin
            state_d = (state_q == GET_ADDR && is_write_q) ? GET_DATA : BUS;
          end
        end else if (RX_TIMEOUT != 0 && rx_tmo_q == RX_LIM) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          rx_tmo_d = rx_tmo_q + 32'd1;
        end
      end
      BUS: begin
        if (!cyc_q) begin
          cyc_d     = 1'b1;
          sel_d     = 4'hF;
          we_d      = is_write_q;
          adr_d     = {addr_q[31:2], 2'b00};
          dat_d     = wdat_q;
          bus_tmo_d = '0;
        end else if (wb_ack_i) begin
          // Ack is checked before the timeout so a coincident ack still completes.
          cyc_d   = 1'b0;
          sel_d   = 4'h0;
          we_d    = 1'b0;
          state_d = SEND;
          if (is_write_q) begin
            rsp_d      = 32'hA5;
            rsp_left_d = 3'd1;
          end else begin
            rsp_d      = wb_dat_i;
            rsp_left_d = 3'd4;
          end
        end else if (BUS_TIMEOUT != 0 && bus_tmo_q == BUS_LIM) begin
          cyc_d      = 1'b0;
          sel_d      = 4'h0;
          we_d       = 1'b0;
          rsp_d      = 32'hEE;
          rsp_left_d = 3'd1;
          err_inc    = 1'b1;
          state_d    = SEND;
        end else begin
          bus_tmo_d = bus_tmo_q + 32'd1;
        end
      end
      SEND: begin
        if (tx_empty) begin
          tx_we_d    = 1'b1;
          tx_data_d  = rsp_q[7:0];
          rsp_d      = {8'h00, rsp_q[31:8]};
          rsp_left_d = rsp_left_q - 3'd1;
          state_d    = SEND_WAIT;
        end
      end
      SEND_WAIT: begin
        state_d = (rsp_left_q == 3'd0) ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase

    err_d = err_q;
    if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      cnt_q      <= 2'd0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rsp_q      <= '0;
      rsp_left_q <= 3'd0;
      rx_re_q    <= 1'b0;
      rx_hold_q  <= 1'b0;
      rx_tmo_q   <= '0;
      bus_tmo_q  <= '0;
      tx_we_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      adr_q      <= '0;
      dat_q      <= '0;
      err_q      <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rsp_q      <= rsp_d;
      rsp_left_q <= rsp_left_d;
      rx_re_q    <= rx_re_d;
      rx_hold_q  <= rx_re_q;
      rx_tmo_q   <= rx_tmo_d;
      bus_tmo_q  <= bus_tmo_d;
      tx_we_q    <= tx_we_d;
      tx_data_q  <= tx_data_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      err_q      <= err_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign rx_re    = rx_re_q;
  assign tx_we    = tx_we_q;
  assign tx_data  = tx_data_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign busy     = busy_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Bench for uart_wb_bridge: UART and Wishbone slave models with scoreboards
// for response bytes and bus cycles.
module tb_uart_wb_bridge;
  localparam int unsigned RX_TMO  = 100;
  localparam int unsigned BUS_TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_re;
  logic        tx_empty = 1'b1;
  logic        tx_we;
  logic [7:0]  tx_data;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  uart_wb_bridge #(.RX_TIMEOUT(RX_TMO), .BUS_TIMEOUT(BUS_TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_re(rx_re),
    .tx_empty(tx_empty), .tx_we(tx_we), .tx_data(tx_data),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .busy(busy), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  rx_last = 8'h00;
  int          rx_stale = 0;
  logic [7:0]  exp_tx[$];
  int          tx_cnt = 0;
  int          tx_busy = 0;
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  logic        exp_we[$];
  logic        exp_chk[$];
  int          bus_cnt = 0;
  int          cyc_hi = 0;
  int          ack_delay = -1;
  logic        ack_hold = 1'b0;
  logic        ack_pulse = 1'b0;
  logic [31:0] slave_rdata = 32'h0;
  int          cyc_n = 0;
  int          last_rx_re_n = -100;
  int          last_tx_we_n = -100;
  logic        cyc_prev = 1'b0;
  logic        rx_re_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // UART and Wishbone slave models, all updated on the falling edge.
  always @(negedge clk) begin
    logic [7:0]  b;
    logic [31:0] a, d;
    logic        w, c;
    cyc_n++;

    if (rx_re) begin
      check_eq("rx_re_single_cycle", {31'b0, rx_re_prev}, 32'd0);
      if (rx_q.size() > 0) rx_last = rx_q.pop_front();
      rx_stale = 2;
      last_rx_re_n = cyc_n;
    end else if (rx_stale > 0) begin
      rx_stale--;
    end
    rx_re_prev = rx_re;
    rx_valid = (rx_stale > 0) || (rx_q.size() > 0);
    rx_data  = (rx_stale > 0) ? rx_last : ((rx_q.size() > 0) ? rx_q[0] : 8'h00);

    if (tx_we) begin
      check_eq("tx_empty_at_we", {31'b0, tx_empty}, 32'd1);
      check_eq("tx_we_gap_ge2", {31'b0, (cyc_n - last_tx_we_n) >= 2}, 32'd1);
      last_tx_we_n = cyc_n;
      tx_cnt++;
      if (exp_tx.size() > 0) begin
        b = exp_tx.pop_front();
        check_eq("tx_data", {24'b0, tx_data}, {24'b0, b});
      end
      tx_busy  = 3 + int'($urandom_range(0, 3));
      tx_empty = 1'b0;
    end else if (tx_busy > 0) begin
      tx_busy--;
      tx_empty = (tx_busy == 0);
    end

    if (wb_cyc_o) begin
      cyc_hi++;
      if (!cyc_prev) check_eq("cyc_after_last_rx_re", 32'(cyc_n - last_rx_re_n), 32'd1);
    end
    cyc_prev = wb_cyc_o;

    if (wb_cyc_o && !wb_ack_i) begin
      if (ack_delay > 0 && cyc_hi == ack_delay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = slave_rdata;
        bus_cnt++;
        check_eq("wb_sel", {28'b0, wb_sel_o}, 32'hF);
        check_eq("wb_stb", {31'b0, wb_stb_o}, 32'd1);
        if (exp_adr.size() > 0) begin
          a = exp_adr.pop_front();
          d = exp_dat.pop_front();
          w = exp_we.pop_front();
          c = exp_chk.pop_front();
          check_eq("wb_adr", wb_adr_o, a);
          check_eq("wb_we", {31'b0, wb_we_o}, {31'b0, w});
          if (c) check_eq("wb_dat_o", wb_dat_o, d);
        end
      end
    end else if (!ack_hold) begin
      wb_ack_i = ack_pulse;
    end
  end

  task automatic push_word(input logic [31:0] wd);
    for (int i = 0; i < 4; i++) rx_q.push_back(wd[8*i +: 8]);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int   n = 0;
    logic seen = 1'b0;
    logic done = 1'b0;
    while (n < budget && !done) begin
      @(negedge clk);
      n++;
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    check_eq({tag, "_completes"}, {31'b0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic start_txn();
    tx_cnt  = 0;
    bus_cnt = 0;
    cyc_hi  = 0;
  endtask

  initial begin
    int   n;
    int   cyc_at_rst;

    repeat (3) @(negedge clk);
    check_eq("rst_rx_re", {31'b0, rx_re}, 32'd0);
    check_eq("rst_tx_we", {31'b0, tx_we}, 32'd0);
    check_eq("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check_eq("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check_eq("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    check_eq("rst_we", {31'b0, wb_we_o}, 32'd0);
    check_eq("rst_sel", {28'b0, wb_sel_o}, 32'd0);
    check_eq("rst_adr", wb_adr_o, 32'd0);
    check_eq("rst_dat", wb_dat_o, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_err", {24'b0, err_cnt}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn reset checked");

    // PING
    start_txn();
    exp_tx.push_back(8'h5A);
    rx_q.push_back(8'h03);
    wait_done("ping", 100);
    check_eq("ping_tx_count", tx_cnt, 1);
    check_eq("ping_no_bus", cyc_hi, 0);
    check_eq("ping_busy", {31'b0, busy}, 32'd0);
    $display("txn PING tx_count=%0d", tx_cnt);

    // WRITE with ack after 3 cycles, ack held high afterwards
    start_txn();
    ack_delay = 3;
    ack_hold  = 1'b1;
    exp_adr.push_back(32'h8000_0010);
    exp_dat.push_back(32'hDEAD_BEEF);
    exp_we.push_back(1'b1);
    exp_chk.push_back(1'b1);
    exp_tx.push_back(8'hA5);
    rx_q.push_back(8'h01);
    push_word(32'h8000_0010);
    push_word(32'hDEAD_BEEF);
    wait_done("write", 200);
    check_eq("write_bus_count", bus_cnt, 1);
    check_eq("write_cyc_cycles", cyc_hi, 3);
    check_eq("write_tx_count", tx_cnt, 1);
    ack_hold = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn WRITE bus=%0d cyc_cycles=%0d tx_count=%0d", bus_cnt, cyc_hi, tx_cnt);

    // READ returning 0x12345678
    start_txn();
    ack_delay   = 2;
    slave_rdata = 32'h1234_5678;
    exp_adr.push_back(32'h8000_0004);
    exp_dat.push_back(32'h0);
    exp_we.push_back(1'b0);
    exp_chk.push_back(1'b0);
    exp_tx.push_back(8'h78);
    exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34);
    exp_tx.push_back(8'h12);
    rx_q.push_back(8'h02);
    push_word(32'h8000_0004);
    wait_done("read", 300);
    check_eq("read_bus_count", bus_cnt, 1);
    check_eq("read_tx_count", tx_cnt, 4);
    check_eq("read_err", {24'b0, err_cnt}, 32'd0);
    $display("txn READ bus=%0d tx_count=%0d", bus_cnt, tx_cnt);

    // Unknown command
    start_txn();
    exp_tx.push_back(8'hEE);
    rx_q.push_back(8'h7F);
    wait_done("badcmd", 100);
    check_eq("badcmd_tx_count", tx_cnt, 1);
    check_eq("badcmd_err", {24'b0, err_cnt}, 32'd1);
    $display("txn BADCMD err_cnt=%0d", err_cnt);

    // READ with no ack: bus timeout
    start_txn();
    ack_delay = -1;
    exp_tx.push_back(8'hEE);
    rx_q.push_back(8'h02);
    push_word(32'h0000_0100);
    wait_done("bustmo", 300);
    check_eq("bustmo_cyc_cycles", cyc_hi, 16);
    check_eq("bustmo_tx_count", tx_cnt, 1);
    check_eq("bustmo_err", {24'b0, err_cnt}, 32'd2);
    $display("txn BUS_TIMEOUT cyc_cycles=%0d err_cnt=%0d", cyc_hi, err_cnt);

    // Partial frame then stall: RX timeout
    start_txn();
    rx_q.push_back(8'h01);
    rx_q.push_back(8'h00);
    wait_done("rxtmo", 400);
    check_eq("rxtmo_tx_count", tx_cnt, 0);
    check_eq("rxtmo_no_bus", cyc_hi, 0);
    check_eq("rxtmo_err", {24'b0, err_cnt}, 32'd3);
    check_eq("rxtmo_rx_drained", rx_q.size(), 0);
    $display("txn RX_TIMEOUT err_cnt=%0d", err_cnt);

    // PING after the timeout
    start_txn();
    exp_tx.push_back(8'h5A);
    rx_q.push_back(8'h03);
    wait_done("ping2", 100);
    check_eq("ping2_tx_count", tx_cnt, 1);
    check_eq("ping2_err", {24'b0, err_cnt}, 32'd3);
    $display("txn PING2 tx_count=%0d", tx_cnt);

    // Reset while the bus cycle is outstanding
    start_txn();
    ack_delay = -1;
    rx_q.push_back(8'h02);
    push_word(32'h0000_0008);
    n = 0;
    while (n < 60 && !wb_cyc_o) begin
      @(negedge clk);
      n++;
    end
    check_eq("rstbus_cyc_seen", {31'b0, wb_cyc_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc_at_rst = cyc_hi;
    check_eq("rstbus_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check_eq("rstbus_stb", {31'b0, wb_stb_o}, 32'd0);
    check_eq("rstbus_sel", {28'b0, wb_sel_o}, 32'd0);
    check_eq("rstbus_busy", {31'b0, busy}, 32'd0);
    check_eq("rstbus_err_cleared", {24'b0, err_cnt}, 32'd0);
    ack_pulse = 1'b1;
    repeat (2) @(negedge clk);
    ack_pulse = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("rstbus_no_tx", tx_cnt, 0);
    check_eq("rstbus_cyc_stays_low", cyc_hi, cyc_at_rst);
    check_eq("rstbus_idle", {31'b0, busy}, 32'd0);
    check_eq("rstbus_tx_pending", exp_tx.size(), 0);
    $display("txn RESET_IN_BUS tx_count=%0d", tx_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
